// File: rtl/seq_param_dec_pkg.sv
// Shared constants for the sequential parameterised decoder: mode encodings
// and the width of the out-of-range event counter.
package seq_param_dec_pkg;

  localparam logic MODE_ONEHOT = 1'b0;
  localparam logic MODE_THERM  = 1'b1;

  localparam int ERR_CNT_W = 8;

endpackage

// File: rtl/seq_param_dec_comb.sv
// Combinational index decoder: one-hot or thermometer word, zeroed with err
// raised when the index falls outside the nbits-wide word.
module param_dec_comb
  import seq_param_dec_pkg::*;
#(
  parameter int nbits = 8,
  parameter int ibits = $clog2(nbits)
) (
  input  logic [ibits-1:0] in_,
  input  logic             mode,
  output logic [nbits-1:0] out,
  output logic             err
);

  localparam bit CHK_RANGE = (nbits < (1 << ibits));

  logic [nbits-1:0] w_word;

  // A power-of-two width has no unreachable index codes, so err folds to 0.
  if (CHK_RANGE) begin : g_range
    assign err = ({1'b0, in_} >= (ibits + 1)'(nbits));
  end else begin : g_norange
    assign err = 1'b0;
  end

  always_comb begin
    w_word = '0;
    for (int i = 0; i < nbits; i++) begin
      if (mode == MODE_THERM) begin
        w_word[i] = (ibits'(i) <= in_);
      end else begin
        w_word[i] = (ibits'(i) == in_);
      end
    end
    out = err ? '0 : w_word;
  end

endmodule

// File: rtl/seq_param_dec.sv
// Single-stage valid/ready decoder register around param_dec_comb.
// Optional macro SEQ_PARAM_DEC_ERR_CNT_EN adds the saturating err_count counter.
module seq_param_dec
  import seq_param_dec_pkg::*;
#(
  parameter int nbits = 8,
  parameter int ibits = $clog2(nbits)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_val,
  output logic                 in_rdy,
  input  logic [ibits-1:0]     in_,
  input  logic                 mode,
  output logic                 out_val,
  input  logic                 out_rdy,
  output logic [nbits-1:0]     out,
  output logic                 out_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  logic [nbits-1:0] w_dec;
  logic             w_err;
  logic             w_in_xfer;
  logic             w_out_xfer;

  logic             r_out_val;
  logic [nbits-1:0] r_out;
  logic             r_out_err;

  param_dec_comb #(.nbits(nbits), .ibits(ibits)) u_dec (
    .in_  (in_),
    .mode (mode),
    .out  (w_dec),
    .err  (w_err)
  );

  // A full stage still accepts when it drains in the same cycle.
  assign in_rdy     = !r_out_val || out_rdy;
  assign w_in_xfer  = in_val && in_rdy;
  assign w_out_xfer = r_out_val && out_rdy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_val <= 1'b0;
      r_out     <= '0;
      r_out_err <= 1'b0;
    end else if (w_in_xfer) begin
      r_out_val <= 1'b1;
      r_out     <= w_dec;
      r_out_err <= w_err;
    end else if (w_out_xfer) begin
      r_out_val <= 1'b0;
    end
  end

  assign out_val = r_out_val;
  assign out     = r_out;
  assign out_err = r_out_err;

`ifdef SEQ_PARAM_DEC_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] r_err_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err_cnt <= '0;
    end else if (w_in_xfer && w_err && (r_err_cnt != '1)) begin
      r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign err_count = r_err_cnt;
`else
  assign err_count = '0;
`endif

endmodule
